fpu_div16: RTL and testbench

Sequential FP16 (IEEE 754 binary16) division coprocessor: fpuOut = fpuIn1 / fpuIn2. It is the inverse-operation counterpart of the FP16 multiply unit and uses the same start/done handshake, fp16_t operands and condition/status outputs. Significands are divided by a radix-2 restoring divider over a fixed number of iterations, then the result is rounded with round-to-nearest-even (RNE) and packed.

---
 rtl/fpu_div16_pkg.sv | 39 +++
 rtl/fpu_div16_divider.sv | 64 ++++++
 rtl/fpu_div16.sv | 223 ++++++++++++++++++++++
 tb/tb_fpu_div16.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_div16_pkg.sv
// Shared FP16 types, constants and state encoding for the FP16 divide coprocessor.
package fpu_div16_pkg;

    localparam int unsigned FP16_EXPW    = 5;
    localparam int unsigned FP16_FRACW   = 10;
    localparam int unsigned FP16_BIAS    = 15;
    localparam int unsigned FP16_EXP_MAX = 31;
    localparam logic [15:0] FP16_QNAN    = 16'h7E00;

    typedef struct packed {
        logic                  sign;
        logic [FP16_EXPW-1:0]  exp;
        logic [FP16_FRACW-1:0] frac;
    } fp16_t;

    typedef enum logic [2:0] {
        DIV_WAIT,
        DIV_PRENORM,
        DIV_ITER,
        DIV_ROUND,
        DIV_DONE
    } fpuDivState_t;

    typedef struct packed {
        logic Z;
        logic C;
        logic N;
        logic V;
    } condCode_t;

    typedef struct packed {
        logic invalid;
        logic divByZero;
        logic overflow;
        logic underflow;
        logic inexact;
    } opStatusFlag_t;

endpackage

// File: rtl/fpu_div16_divider.sv
// Radix-2 restoring significand divider: one quotient bit per step, MSB first.
module fpu_divider16
    import fpu_div16_pkg::*;
#(
    parameter  int unsigned QW = 14,
    localparam int unsigned CW = $clog2(QW + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [11:0]   dividend_i,
    input  logic [10:0]   divisor_i,
    output logic [QW-1:0] quotient_o,
    output logic          sticky_o,
    output logic [CW-1:0] count_o
);

    logic [11:0]   rem_q, rem_d;
    logic [10:0]   div_q, div_d;
    logic [QW-1:0] quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [12:0]   diff;
    logic          ge;

    always_comb begin
        diff  = {1'b0, rem_q} - {2'b00, div_q};
        ge    = ~diff[12];
        rem_d = rem_q;
        div_d = div_q;
        quo_d = quo_q;
        cnt_d = cnt_q;
        if (load_i) begin
            rem_d = dividend_i;
            div_d = divisor_i;
            quo_d = '0;
            cnt_d = '0;
        end else if (step_i) begin
            // Partial remainder stays below twice the divisor, so 12 bits hold it after the shift.
            rem_d = (ge ? diff[11:0] : rem_q) << 1;
            quo_d = {quo_q[QW-2:0], ge};
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q <= '0;
            div_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            div_q <= div_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
        end
    end

    assign quotient_o = quo_q;
    assign sticky_o   = |rem_q;
    assign count_o    = cnt_q;

endmodule

// File: rtl/fpu_div16.sv
// Sequential FP16 divider: operand capture, pre-normalization, iterative divide,
// RNE rounding with denormal/overflow handling and IEEE special cases.
module fpu_div16
    import fpu_div16_pkg::*;
#(
    parameter int unsigned QW = 14
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  fp16_t         fpuIn1,
    input  fp16_t         fpuIn2,
    output fp16_t         fpuOut,
    output logic          done,
    output condCode_t     condCodes,
    output opStatusFlag_t opStatusFlags
);

    localparam int unsigned ITERS = QW;
    localparam int unsigned CW    = $clog2(ITERS + 1);

    fpuDivState_t      state_q, state_d;
    fp16_t             a_q, a_d, b_q, b_d;
    logic signed [6:0] eq_q, eq_d;
    fp16_t             out_q, out_d;
    opStatusFlag_t     flags_q, flags_d;

    logic              div_load, div_step;
    logic [QW-1:0]     div_quo;
    logic              div_sticky;
    logic [CW-1:0]     div_cnt;

    logic [10:0]       m1_raw, m2_raw, m1_n, m2_n;
    logic [3:0]        sh1, sh2;
    logic signed [6:0] e1_n, e2_n, eq_pre;

    fp16_t             res;
    opStatusFlag_t     res_flags;

    function automatic logic [3:0] lead_zeros(input logic [10:0] m);
        logic [3:0] n;
        n = 4'd11;
        for (int unsigned i = 0; i < 11; i++) begin
            if (m[i]) n = 4'(10 - i);
        end
        return n;
    endfunction

    always_comb begin
        m1_raw = {|a_q.exp, a_q.frac};
        m2_raw = {|b_q.exp, b_q.frac};
        sh1    = lead_zeros(m1_raw);
        sh2    = lead_zeros(m2_raw);
        m1_n   = m1_raw << sh1;
        m2_n   = m2_raw << sh2;
        e1_n   = (a_q.exp != '0) ? $signed({2'b00, a_q.exp}) : 7'sd1 - $signed({3'b000, sh1});
        e2_n   = (b_q.exp != '0) ? $signed({2'b00, b_q.exp}) : 7'sd1 - $signed({3'b000, sh2});
        eq_pre = e1_n - e2_n + $signed(7'(FP16_BIAS));
    end

    fpu_divider16 #(.QW(QW)) u_div (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (div_load),
        .step_i     (div_step),
        .dividend_i ({1'b0, m1_n}),
        .divisor_i  (m2_n),
        .quotient_o (div_quo),
        .sticky_o   (div_sticky),
        .count_o    (div_cnt)
    );

    logic [QW-1:0]     qn;
    logic signed [6:0] eqn, eqr, shd;
    logic [10:0]       sig, sigd, sumd;
    logic [11:0]       sum;
    logic [9:0]        frac_r;
    logic [12:0]       ext, xsh, lost_mask;
    logic              g, r, s, up, gd, rd, s2, upd;
    logic              sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    always_comb begin
        res       = '0;
        res_flags = '0;
        qn        = div_quo[QW-1] ? div_quo : {div_quo[QW-2:0], 1'b0};
        eqn       = div_quo[QW-1] ? eq_q : eq_q - 7'sd1;
        sig       = qn[QW-1 -: 11];
        g         = qn[QW-12];
        r         = qn[QW-13];
        s         = (|qn[QW-14:0]) | div_sticky;
        up        = g & (r | s | sig[0]);
        sum       = {1'b0, sig} + 12'(up);
        frac_r    = sum[11] ? sum[10:1] : sum[9:0];
        eqr       = sum[11] ? eqn + 7'sd1 : eqn;
        shd       = 7'sd1 - eqn;
        ext       = {sig, g, r};
        xsh       = '0;
        lost_mask = '0;
        sigd      = '0;
        gd        = 1'b0;
        rd        = 1'b0;
        s2        = s;
        upd       = 1'b0;
        sumd      = '0;
        sign      = a_q.sign ^ b_q.sign;

        a_nan  = (a_q.exp == 5'(FP16_EXP_MAX)) && (a_q.frac != '0);
        b_nan  = (b_q.exp == 5'(FP16_EXP_MAX)) && (b_q.frac != '0);
        a_inf  = (a_q.exp == 5'(FP16_EXP_MAX)) && (a_q.frac == '0);
        b_inf  = (b_q.exp == 5'(FP16_EXP_MAX)) && (b_q.frac == '0);
        a_zero = (a_q.exp == '0) && (a_q.frac == '0);
        b_zero = (b_q.exp == '0) && (b_q.frac == '0);

        // Tiny results are shifted from the unrounded quotient so rounding happens only once.
        if (eqn <= 7'sd0) begin
            if (shd >= 7'sd13) begin
                res                 = {sign, 15'h0000};
                res_flags.inexact   = 1'b1;
                res_flags.underflow = 1'b1;
            end else begin
                xsh       = ext >> shd[3:0];
                lost_mask = (13'h0001 << shd[3:0]) - 13'h0001;
                s2        = s | (|(ext & lost_mask));
                sigd      = xsh[12:2];
                gd        = xsh[1];
                rd        = xsh[0];
                upd       = gd & (rd | s2 | sigd[0]);
                sumd      = sigd + 11'(upd);
                res       = {sign, 4'h0, sumd};
                res_flags.inexact   = gd | rd | s2;
                res_flags.underflow = gd | rd | s2;
            end
        end else if (eqr >= $signed(7'(FP16_EXP_MAX))) begin
            res                = {sign, 5'h1F, 10'h000};
            res_flags.overflow = 1'b1;
            res_flags.inexact  = 1'b1;
        end else begin
            res               = {sign, eqr[4:0], frac_r};
            res_flags.inexact = g | r | s;
        end

        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            res               = FP16_QNAN;
            res_flags         = '0;
            res_flags.invalid = 1'b1;
        end else if (a_inf) begin
            res       = {sign, 5'h1F, 10'h000};
            res_flags = '0;
        end else if (b_zero) begin
            res                 = {sign, 5'h1F, 10'h000};
            res_flags           = '0;
            res_flags.divByZero = 1'b1;
        end else if (b_inf || a_zero) begin
            res       = {sign, 15'h0000};
            res_flags = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        eq_d     = eq_q;
        out_d    = out_q;
        flags_d  = flags_q;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state_q)
            DIV_WAIT, DIV_DONE: begin
                if (start) begin
                    a_d     = fpuIn1;
                    b_d     = fpuIn2;
                    state_d = DIV_PRENORM;
                end
            end
            DIV_PRENORM: begin
                div_load = 1'b1;
                eq_d     = eq_pre;
                state_d  = DIV_ITER;
            end
            DIV_ITER: begin
                div_step = 1'b1;
                if (div_cnt == CW'(ITERS - 1)) state_d = DIV_ROUND;
            end
            DIV_ROUND: begin
                out_d   = res;
                flags_d = res_flags;
                state_d = DIV_DONE;
            end
            default: state_d = DIV_WAIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DIV_WAIT;
            a_q     <= '0;
            b_q     <= '0;
            eq_q    <= '0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            eq_q    <= eq_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        condCodes   = '0;
        condCodes.Z = (out_q[14:0] == '0);
        condCodes.N = out_q.sign;
        condCodes.V = flags_q.overflow;
    end

    assign fpuOut        = out_q;
    assign opStatusFlags = flags_q;
    assign done          = (state_q == DIV_DONE);

endmodule

// File: tb/tb_fpu_div16.sv
// Scoreboard bench for fpu_div16: directed vectors push expectations, a negedge monitor checks them.
module tb_fpu_div16;
    import fpu_div16_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    fp16_t         in1, in2;
    fp16_t         out_w;
    logic          done;
    condCode_t     cc_w;
    opStatusFlag_t fl_w;

    fpu_div16 #(.QW(14)) dut (
        .clock         (clk),
        .reset         (rst),
        .start         (start),
        .fpuIn1        (in1),
        .fpuIn2        (in2),
        .fpuOut        (out_w),
        .done          (done),
        .condCodes     (cc_w),
        .opStatusFlags (fl_w)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] o;
        logic [4:0]  f;
        int unsigned t;
    } exp_t;

    typedef struct {
        int unsigned kind;
        logic [15:0] o;
        logic [4:0]  f;
    } now_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] o;
        logic [4:0]  f;
    } vec_t;

    exp_t        q_exp[$];
    now_t        q_now[$];
    vec_t        vt[$];
    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    logic        done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [3:0] cc_of(input logic [15:0] o, input logic [4:0] f);
        return {o[14:0] == 15'h0000, 1'b0, o[15], f[2]};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        now_t k;
        if (done && !done_prev) begin
            if (q_exp.size() == 0) begin
                fail_now("spurious_done");
            end else begin
                e = q_exp.pop_front();
                chk("fpuOut", 32'(out_w), 32'(e.o));
                chk("flags", 32'(fl_w), 32'(e.f));
                chk("condCodes", 32'(cc_w), 32'(cc_of(e.o, e.f)));
                chk("latency", cyc - e.t, 32'd16);
            end
        end
        done_prev = done;
        while (q_now.size() != 0) begin
            k = q_now.pop_front();
            case (k.kind)
                0: begin
                    chk("state_done", 32'(done), 32'd0);
                    chk("state_out", 32'(out_w), 32'(k.o));
                    chk("state_flags", 32'(fl_w), 32'(k.f));
                    chk("state_cc", 32'(cc_w), 32'(cc_of(k.o, k.f)));
                end
                1: chk("done_drop", 32'(done), 32'd0);
                2: fail_now("done_timeout");
                default: chk("pending_results", q_exp.size(), 32'd0);
            endcase
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] o,
                         input logic [4:0] f, input bit push);
        @(negedge clk);
        start = 1'b1;
        in1   = a;
        in2   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        in1   = 16'($urandom);
        in2   = 16'($urandom);
        if (push) q_exp.push_back('{o, f, cyc});
        q_now.push_back('{1, 16'h0000, 5'b00000});
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            if (done) got = 1'b1;
        end
        if (!got) q_now.push_back('{2, 16'h0000, 5'b00000});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // flags: {invalid, divByZero, overflow, underflow, inexact}
        vt.push_back('{16'h4600, 16'h4000, 16'h4200, 5'b00000});
        vt.push_back('{16'h3C00, 16'h4200, 16'h3555, 5'b00001});
        vt.push_back('{16'h3C00, 16'h0000, 16'h7C00, 5'b01000});
        vt.push_back('{16'h0000, 16'h0000, 16'h7E00, 5'b10000});
        vt.push_back('{16'h7BFF, 16'h0001, 16'h7C00, 5'b00101});
        vt.push_back('{16'h0400, 16'h7800, 16'h0000, 5'b00011});
        vt.push_back('{16'h0200, 16'h3800, 16'h0400, 5'b00000});
        vt.push_back('{16'hC000, 16'h4000, 16'hBC00, 5'b00000});
        vt.push_back('{16'h4900, 16'h4200, 16'h42AB, 5'b00001});
        vt.push_back('{16'h3C00, 16'h4500, 16'h3266, 5'b00001});
        vt.push_back('{16'h0003, 16'h4000, 16'h0002, 5'b00011});
        vt.push_back('{16'h0001, 16'h4000, 16'h0000, 5'b00011});
        vt.push_back('{16'h7C00, 16'h4000, 16'h7C00, 5'b00000});
        vt.push_back('{16'h3C00, 16'h7C00, 16'h0000, 5'b00000});
        vt.push_back('{16'h8000, 16'h3C00, 16'h8000, 5'b00000});
        vt.push_back('{16'h7E00, 16'h3C00, 16'h7E00, 5'b10000});
        vt.push_back('{16'h7C00, 16'h7C00, 16'h7E00, 5'b10000});
        vt.push_back('{16'hFC00, 16'h0000, 16'hFC00, 5'b00000});
        vt.push_back('{16'h3C00, 16'h8000, 16'hFC00, 5'b01000});

        rst   = 1'b1;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        repeat (3) @(posedge clk);
        #1;
        q_now.push_back('{0, 16'h0000, 5'b00000});
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[i]) begin
            issue(vt[i].a, vt[i].b, vt[i].o, vt[i].f, 1'b1);
            wait_done();
        end

        // A second start during ITER must not disturb the divide in flight.
        issue(16'h4600, 16'h4000, 16'h4200, 5'b00000, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        in1   = 16'h3C00;
        in2   = 16'h0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        issue(16'h3C00, 16'h4200, 16'h3555, 5'b00001, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q_now.push_back('{0, 16'h0000, 5'b00000});
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(posedge clk);

        issue(16'hC000, 16'h4000, 16'hBC00, 5'b00000, 1'b1);
        wait_done();
        issue(16'h3C00, 16'h4200, 16'h3555, 5'b00001, 1'b1);
        wait_done();

        repeat (3) @(posedge clk);
        #1;
        q_now.push_back('{3, 16'h0000, 5'b00000});
        @(negedge clk);
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
